// File: rtl/dmem_req_fsm.sv
`default_nettype none
// ============================================================================
// Module   : dmem_req_fsm
// Purpose  : M-stage data-memory request engine (valid/addr_ok/data_ok bus).
//            Optional perf counters: define DMEM_REQ_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================

package dmem_req_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;
endpackage

module dmem_req_fsm
    import dmem_req_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef DMEM_REQ_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m_vreq,
    input  logic [ADDR_W-1:0] m_addr,
    input  msize_t            m_size,
    input  logic [3:0]        m_strobe,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic              m_hold,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output msize_t            dreq_size,
    output logic [3:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic [DATA_W-1:0] m_data,
`ifdef DMEM_REQ_PERF_EN
    output logic [CNT_W-1:0]  perf_loads,
    output logic [CNT_W-1:0]  perf_stores,
    output logic [CNT_W-1:0]  perf_stall_cycles,
`endif
    output logic              mem_stall
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_DONE    = 3'd3,
        S_DRAIN_A = 3'd4,
        S_DRAIN_D = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_valid;
    logic [ADDR_W-1:0]  r_addr;
    msize_t             r_size;
    logic [3:0]         r_strobe;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_mdata;

    logic [ADDR_W-1:0]  w_paddr;
    logic               w_is_load;
    logic               w_stall;
    logic               w_enter_done;

    // kseg0/kseg1 fold onto the low 512 MB of physical space
    assign w_paddr = (m_addr[ADDR_W-1 -: 2] == 2'b10) ? {3'b000, m_addr[ADDR_W-4:0]} : m_addr;

    assign w_is_load    = (r_strobe == 4'b0000);
    assign w_stall      = ((r_state == S_IDLE) && m_vreq && !flush) ||
                          (r_state == S_REQ) || (r_state == S_WAIT) ||
                          (r_state == S_DRAIN_A) || (r_state == S_DRAIN_D);
    assign w_enter_done = ((r_state == S_REQ) && dresp_addr_ok && dresp_data_ok) ||
                          ((r_state == S_WAIT) && dresp_data_ok);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_addr   <= '0;
            r_size   <= MSIZE1;
            r_strobe <= 4'b0000;
            r_wdata  <= '0;
            r_mdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m_vreq && !flush) begin
                        r_addr   <= w_paddr;
                        r_size   <= m_size;
                        r_strobe <= m_strobe;
                        r_wdata  <= m_wdata;
                        r_valid  <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dresp_addr_ok && dresp_data_ok) begin
                        r_valid <= 1'b0;
                        if (w_is_load) r_mdata <= dresp_data;
                        r_state <= S_DONE;
                    end else if (dresp_addr_ok) begin
                        r_valid <= 1'b0;
                        r_state <= S_WAIT;
                    end else if (flush) begin
                        // request already visible on the bus: keep valid until accepted
                        r_state <= S_DRAIN_A;
                    end
                end
                S_WAIT: begin
                    if (dresp_data_ok) begin
                        if (w_is_load) r_mdata <= dresp_data;
                        r_state <= S_DONE;
                    end else if (flush) begin
                        r_state <= S_DRAIN_D;
                    end
                end
                S_DONE: begin
                    if (!m_hold || flush) r_state <= S_IDLE;
                end
                S_DRAIN_A: begin
                    if (dresp_addr_ok) begin
                        r_valid <= 1'b0;
                        r_state <= dresp_data_ok ? S_IDLE : S_DRAIN_D;
                    end
                end
                S_DRAIN_D: begin
                    if (dresp_data_ok) r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_REQ_PERF_EN
    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_loads;
    logic [CNT_W-1:0] r_stores;
    logic [CNT_W-1:0] r_stalls;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_loads  <= '0;
            r_stores <= '0;
            r_stalls <= '0;
        end else begin
            if (w_enter_done && w_is_load && (r_loads != '1))
                r_loads <= r_loads + c_one;
            if (w_enter_done && !w_is_load && (r_stores != '1))
                r_stores <= r_stores + c_one;
            if (w_stall && (r_stalls != '1))
                r_stalls <= r_stalls + c_one;
        end
    end

    assign perf_loads        = r_loads;
    assign perf_stores       = r_stores;
    assign perf_stall_cycles = r_stalls;
`endif

    assign dreq_valid  = r_valid;
    assign dreq_addr   = r_addr;
    assign dreq_size   = r_size;
    assign dreq_strobe = r_strobe;
    assign dreq_data   = r_wdata;
    assign m_data      = r_mdata;
    assign mem_stall   = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_dmem_req_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_req_fsm
// Purpose  : directed self-checking bench for dmem_req_fsm
// Revision : 1.0 - initial release
// ============================================================================

module tb_dmem_req_fsm;
    import dmem_req_pkg::*;

    logic        clk;
    logic        resetn;
    logic        m_vreq;
    logic [31:0] m_addr;
    msize_t      m_size;
    logic [3:0]  m_strobe;
    logic [31:0] m_wdata;
    logic        m_hold;
    logic        flush;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    msize_t      dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;
    logic [31:0] m_data;
    logic        mem_stall;
`ifdef DMEM_REQ_PERF_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_stall_cycles;
`endif

    int n_cmp    = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int stall_tot = 0;

    dmem_req_fsm dut (
        .clk               (clk),
        .resetn            (resetn),
        .m_vreq            (m_vreq),
        .m_addr            (m_addr),
        .m_size            (m_size),
        .m_strobe          (m_strobe),
        .m_wdata           (m_wdata),
        .m_hold            (m_hold),
        .flush             (flush),
        .dreq_valid        (dreq_valid),
        .dreq_addr         (dreq_addr),
        .dreq_size         (dreq_size),
        .dreq_strobe       (dreq_strobe),
        .dreq_data         (dreq_data),
        .dresp_addr_ok     (dresp_addr_ok),
        .dresp_data_ok     (dresp_data_ok),
        .dresp_data        (dresp_data),
        .m_data            (m_data),
`ifdef DMEM_REQ_PERF_EN
        .perf_loads        (perf_loads),
        .perf_stores       (perf_stores),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .mem_stall         (mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bus acceptances seen on the handshake
    always @(posedge clk) if (resetn && dreq_valid && dresp_addr_ok) n_acc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic es, input logic ev);
        @(negedge clk);
        chk({tag, "_stall"}, 64'(mem_stall), 64'(es));
        chk({tag, "_valid"}, 64'(dreq_valid), 64'(ev));
        if (es) stall_tot++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input logic [31:0] a, input msize_t sz,
                           input logic [3:0] st, input logic [31:0] d);
        chk({tag, "_addr"},   64'(dreq_addr),   64'(a));
        chk({tag, "_size"},   64'(dreq_size),   64'(sz));
        chk({tag, "_strobe"}, 64'(dreq_strobe), 64'(st));
        chk({tag, "_wdata"},  64'(dreq_data),   64'(d));
    endtask

    task automatic set_req(input logic [31:0] a, input msize_t sz, input logic [3:0] st,
                           input logic [31:0] d);
        m_vreq = 1'b1; m_addr = a; m_size = sz; m_strobe = st; m_wdata = d;
    endtask

    // minimum-latency access: addr_ok and data_ok on the first REQ cycle
    task automatic do_xfer(input string tag, input logic [31:0] a, input logic [31:0] pa,
                           input logic [3:0] st, input logic [31:0] rd, input logic [31:0] exp_m);
        set_req(a, MSIZE4, st, 32'h5555_AAAA);
        step({tag, "_idle"}, 1'b1, 1'b0);
        chk_req({tag, "_req"}, pa, MSIZE4, st, 32'h5555_AAAA);
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = rd;
        step({tag, "_req"}, 1'b1, 1'b1);
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; m_vreq = 1'b0;
        chk({tag, "_mdata"}, 64'(m_data), 64'(exp_m));
        step({tag, "_done"}, 1'b0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0; m_vreq = 1'b0; m_addr = '0; m_size = MSIZE1; m_strobe = '0;
        m_wdata = '0; m_hold = 1'b0; flush = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;

        @(negedge clk);
        chk("rst_valid", 64'(dreq_valid), 64'd0);
        chk_req("rst", 32'h0, MSIZE1, 4'h0, 32'h0);
        chk("rst_mdata", 64'(m_data), 64'd0);
        chk("rst_stall", 64'(mem_stall), 64'd0);
        #2 resetn = 1'b1;
        @(posedge clk); #1;

        // LW through kseg0, zero-wait
        do_xfer("lw", 32'h8000_0010, 32'h0000_0010, 4'b0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        chk("lw_acc", 64'(n_acc), 64'd1);

        // SB through kseg1: addr_ok after 3 cycles, data_ok 2 cycles later -> 7 stall cycles
        set_req(32'hA000_0003, MSIZE1, 4'b1000, 32'h7777_7777);
        step("sb_idle", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_req("sb_hold", 32'h0000_0003, MSIZE1, 4'b1000, 32'h7777_7777);
            step("sb_req", 1'b1, 1'b1);
        end
        dresp_addr_ok = 1'b1;
        chk_req("sb_acc", 32'h0000_0003, MSIZE1, 4'b1000, 32'h7777_7777);
        step("sb_reqok", 1'b1, 1'b1);
        dresp_addr_ok = 1'b0;
        step("sb_wait", 1'b1, 1'b0);
        dresp_data_ok = 1'b1; dresp_data = 32'hCAFE_0000;
        step("sb_wait_ok", 1'b1, 1'b0);
        dresp_data_ok = 1'b0; m_vreq = 1'b0;
        chk("sb_mdata", 64'(m_data), 64'hDEAD_BEEF);
        step("sb_done", 1'b0, 1'b0);
        chk("sb_acc", 64'(n_acc), 64'd2);

        // flush in REQ before addr_ok: request drains, response discarded
        set_req(32'h0000_0100, MSIZE4, 4'b0000, 32'h0);
        step("fl_idle", 1'b1, 1'b0);
        flush = 1'b1;
        step("fl_req", 1'b1, 1'b1);
        flush = 1'b0; m_vreq = 1'b0;
        step("fl_drain_a", 1'b1, 1'b1);
        dresp_addr_ok = 1'b1;
        step("fl_drain_a_ok", 1'b1, 1'b1);
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b1; dresp_data = 32'h1234_5678;
        step("fl_drain_d", 1'b1, 1'b0);
        dresp_data_ok = 1'b0;
        chk("fl_mdata", 64'(m_data), 64'hDEAD_BEEF);
        step("fl_idle2", 1'b0, 1'b0);
        chk("fl_acc", 64'(n_acc), 64'd3);

        // m_hold in DONE with m_vreq still high: no reissue
        set_req(32'h0000_0200, MSIZE2, 4'b0000, 32'h0);
        step("hd_idle", 1'b1, 1'b0);
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h0000_BEEF;
        step("hd_req", 1'b1, 1'b1);
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; m_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("hd_mdata", 64'(m_data), 64'h0000_BEEF);
            step("hd_done", 1'b0, 1'b0);
        end
        m_hold = 1'b0; m_vreq = 1'b0;
        step("hd_release", 1'b0, 1'b0);
        chk("hd_acc", 64'(n_acc), 64'd4);

        // next load goes to WAIT, then async reset mid-transaction
        set_req(32'h0000_0300, MSIZE4, 4'b0000, 32'h0);
        step("rw_idle", 1'b1, 1'b0);
        dresp_addr_ok = 1'b1;
        step("rw_req", 1'b1, 1'b1);
        dresp_addr_ok = 1'b0; m_vreq = 1'b0;
        @(negedge clk);
        chk("rw_wait_stall", 64'(mem_stall), 64'd1);
        #1 resetn = 1'b0;
        #1;
        chk("rw_rst_valid", 64'(dreq_valid), 64'd0);
        chk_req("rw_rst", 32'h0, MSIZE1, 4'h0, 32'h0);
        chk("rw_rst_mdata", 64'(m_data), 64'd0);
        chk("rw_rst_stall", 64'(mem_stall), 64'd0);
        stall_tot = 0;
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        dresp_data_ok = 1'b1; dresp_data = 32'hBAD0_BAD0;
        step("rw_late", 1'b0, 1'b0);
        dresp_data_ok = 1'b0;
        chk("rw_late_mdata", 64'(m_data), 64'd0);
        step("rw_idle2", 1'b0, 1'b0);
        chk("rw_acc", 64'(n_acc), 64'd5);

        // counter workload: 2 loads, 1 store, 1 flushed load
        do_xfer("pl1", 32'h8000_0040, 32'h0000_0040, 4'b0000, 32'h1111_1111, 32'h1111_1111);
        do_xfer("pl2", 32'h0000_0044, 32'h0000_0044, 4'b0000, 32'h2222_2222, 32'h2222_2222);
        do_xfer("ps",  32'hA000_0048, 32'h0000_0048, 4'b1111, 32'h3333_3333, 32'h2222_2222);
        set_req(32'h0000_0050, MSIZE4, 4'b0000, 32'h0);
        step("pf_idle", 1'b1, 1'b0);
        flush = 1'b1;
        step("pf_req", 1'b1, 1'b1);
        flush = 1'b0; m_vreq = 1'b0;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h9999_9999;
        step("pf_drain", 1'b1, 1'b1);
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        chk("pf_mdata", 64'(m_data), 64'h2222_2222);
        step("pf_idle2", 1'b0, 1'b0);
        chk("pf_acc", 64'(n_acc), 64'd9);
`ifdef DMEM_REQ_PERF_EN
        chk("perf_loads",  64'(perf_loads),  64'd2);
        chk("perf_stores", 64'(perf_stores), 64'd1);
        chk("perf_stall_hand", 64'(perf_stall_cycles), 64'd9);
        chk("perf_stall_sum",  64'(perf_stall_cycles), 64'(stall_tot));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
